// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for the 2-bit 4x1 mux: owns S1/S0 and registers the
// selected word with a valid strobe. Define MUX4_ARB_TIMEOUT_EN to enforce the MAX_HOLD timeout.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] Req,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] C,
  input  logic [1:0] D,
  output logic [3:0] Gnt,
  output logic       S1,
  output logic       S0,
  output logic [1:0] Out,
  output logic       OutValid
);

  typedef enum logic {IDLE, GRANT} state_e;

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD must be in 1..15");
  end

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic [3:0] req_other;
  logic [1:0] sel_data;
  logic       timeout;

  // First requester found scanning ptr, ptr+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    req_other        = Req;
    req_other[sel_q] = 1'b0;
    case (sel_q)
      2'd0:    sel_data = A;
      2'd1:    sel_data = B;
      2'd2:    sel_data = C;
      default: sel_data = D;
    endcase
  end

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [3:0] hold_q, hold_d;

  assign timeout = (state_q == GRANT) && Req[sel_q] && (hold_q == HOLD_LAST) && (|req_other);

  // Counts captures of the current grantee, saturating; any hand-off or idle restarts it.
  always_comb begin
    hold_d = 4'd0;
    if (state_q == GRANT && Req[sel_q] && !timeout)
      hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 4'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) hold_q <= 4'd0;
    else        hold_q <= hold_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      out_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: every next-state value gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    out_d   = out_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|Req) begin
          state_d = GRANT;
          sel_d   = rr_pick(Req, ptr_q);
        end
      end
      GRANT: begin
        if (Req[sel_q]) begin
          out_d   = sel_data;
          valid_d = 1'b1;
          if (timeout) begin
            ptr_d = sel_q + 2'd1;
            sel_d = rr_pick(req_other, sel_q + 2'd1);
          end
        end else begin
          ptr_d = sel_q + 2'd1;
          if (|req_other) sel_d = rr_pick(req_other, sel_q + 2'd1);
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Selects hold their last value while idle; Gnt is decoded only in GRANT.
  always_comb begin
    Gnt = 4'b0000;
    if (state_q == GRANT) Gnt[sel_q] = 1'b1;
    {S1, S0} = sel_q;
    Out      = out_q;
    OutValid = valid_q;
  end

endmodule
